// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register offsets, bit indices
// and the default window base.
package mmio_pkg;

   localparam logic [31:0] DEFAULT_IO_BASE = 32'h1001_0040;

   localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
   localparam logic [2:0] OFF_PORT_IN   = 3'd1;
   localparam logic [2:0] OFF_STATUS    = 3'd2;
   localparam logic [2:0] OFF_TIMER_CMP = 3'd3;
   localparam logic [2:0] OFF_TIMER_CNT = 3'd4;
   localparam logic [2:0] OFF_CTRL      = 3'd5;

   localparam int unsigned STATUS_IN_CHANGED  = 0;
   localparam int unsigned STATUS_TMR_EXPIRED = 1;

   localparam int unsigned CTRL_TMR_EN      = 0;
   localparam int unsigned CTRL_AUTO_RELOAD = 1;
   localparam int unsigned CTRL_IRQ_EN_IN   = 2;
   localparam int unsigned CTRL_IRQ_EN_TMR  = 3;

   // Window match ignores the low five address bits (32-byte window).
   function automatic logic inWindow(input logic [31:0] addr, input logic [31:0] base);
      return addr[31:5] == base[31:5];
   endfunction

endpackage

// File: rtl/io_input_sync.sv
// Two-flop synchronizer for the 8-bit input port plus a history register
// used to flag changes of the synchronized value.
module io_input_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] portIn,
   output logic [7:0] syncIn,
   output logic       changedPulse
);

   logic [7:0] stage1Q;
   logic [7:0] syncQ;
   logic [7:0] prevQ;

   always_ff @(posedge clk) begin
      if (reset) begin
         stage1Q <= '0;
         syncQ   <= '0;
         prevQ   <= '0;
      end else begin
         stage1Q <= portIn;
         syncQ   <= stage1Q;
         prevQ   <= syncQ;
      end
   end

   assign syncIn       = syncQ;
   assign changedPulse = (syncQ != prevQ);

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O slave on the data-memory bus: output port, synchronized
// input port with sticky change flag, and a compare timer with interrupt.
module mmio_port_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] IO_BASE     = DEFAULT_IO_BASE,
   parameter int unsigned TIMER_WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [7:0]  PortIn,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic [31:0] PortOut,
   output logic        Irq
);

   logic [2:0]             offset;
   logic                   wrEn;
   logic                   unusedAddr;

   logic [31:0]            portOutQ, portOutD;
   logic [1:0]             statusQ, statusD;
   logic [3:0]             ctrlQ, ctrlD;
   logic [TIMER_WIDTH-1:0] cmpQ, cmpD;
   logic [TIMER_WIDTH-1:0] cntQ, cntD;

   logic [7:0]             syncIn;
   logic                   changedPulse;
   logic                   tmrExpire;
   logic [1:0]             w1cMask;

   assign Hit        = inWindow(Address, IO_BASE);
   assign offset     = Address[4:2];
   assign wrEn       = Hit & MemWrite;
   assign unusedAddr = ^Address[1:0];

   io_input_sync uInputSync (
      .clk          (clk),
      .reset        (reset),
      .portIn       (PortIn),
      .syncIn       (syncIn),
      .changedPulse (changedPulse)
   );

   always_comb begin
      portOutD  = portOutQ;
      cmpD      = cmpQ;
      ctrlD     = ctrlQ;
      cntD      = cntQ;
      tmrExpire = 1'b0;
      w1cMask   = '0;

      if (ctrlQ[CTRL_TMR_EN]) begin
         if (cntQ == cmpQ) begin
            tmrExpire = 1'b1;
            cntD      = '0;
            if (!ctrlQ[CTRL_AUTO_RELOAD]) begin
               ctrlD[CTRL_TMR_EN] = 1'b0;
            end
         end else begin
            cntD = cntQ + TIMER_WIDTH'(1);
         end
      end

      // Software writes are applied after the timer update so they take priority.
      if (wrEn) begin
         unique case (offset)
            OFF_PORT_OUT:  portOutD = WriteData;
            OFF_STATUS:    w1cMask  = WriteData[1:0];
            OFF_TIMER_CMP: cmpD     = WriteData[TIMER_WIDTH-1:0];
            OFF_CTRL: begin
               ctrlD = WriteData[3:0];
               if (!ctrlQ[CTRL_TMR_EN] && WriteData[CTRL_TMR_EN]) begin
                  cntD = '0;
               end
            end
            default: ;
         endcase
      end

      // Set beats clear when both happen in the same cycle.
      statusD = (statusQ & ~w1cMask);
      statusD[STATUS_IN_CHANGED]  = statusD[STATUS_IN_CHANGED] | changedPulse;
      statusD[STATUS_TMR_EXPIRED] = statusD[STATUS_TMR_EXPIRED] | tmrExpire;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         portOutQ <= '0;
         statusQ  <= '0;
         ctrlQ    <= '0;
         cmpQ     <= '1;
         cntQ     <= '0;
      end else begin
         portOutQ <= portOutD;
         statusQ  <= statusD;
         ctrlQ    <= ctrlD;
         cmpQ     <= cmpD;
         cntQ     <= cntD;
      end
   end

   always_comb begin
      ReadData = '0;
      if (Hit && MemRead) begin
         unique case (offset)
            OFF_PORT_OUT:  ReadData = portOutQ;
            OFF_PORT_IN:   ReadData = {24'b0, syncIn};
            OFF_STATUS:    ReadData = {30'b0, statusQ};
            OFF_TIMER_CMP: ReadData = 32'(cmpQ);
            OFF_TIMER_CNT: ReadData = 32'(cntQ);
            OFF_CTRL:      ReadData = {28'b0, ctrlQ};
            default:       ReadData = '0;
         endcase
      end
   end

   assign PortOut = portOutQ;
   assign Irq     = (statusQ[STATUS_IN_CHANGED]  & ctrlQ[CTRL_IRQ_EN_IN]) |
                    (statusQ[STATUS_TMR_EXPIRED] & ctrlQ[CTRL_IRQ_EN_TMR]);

endmodule
